// File: rtl/keypad_operand_capture.sv
// Decodes one-hot keypad presses into key codes, acknowledges each accepted press,
// and assembles two BCD operands (A then B) handed off with a valid/ready handshake.
module keypad_operand_capture #(
    parameter int WIDTH    = 4,
    parameter int N_DIGITS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0]                 pressed_col_in,
    input  logic [WIDTH-1:0]                 pressed_row_in,
    input  logic                             pressed_valid,
    output logic                             ack_read,
    output logic [3:0]                       key_code,
    output logic                             key_strobe,
    output logic                             entry_sel,
    output logic [$clog2(N_DIGITS+1)-1:0]    digit_count,
    output logic [4*N_DIGITS-1:0]            operand_a,
    output logic [4*N_DIGITS-1:0]            operand_b,
    output logic                             result_valid,
    input  logic                             result_ready
);

    localparam int DW = $clog2(N_DIGITS + 1);
    localparam int OW = 4 * N_DIGITS;
    localparam logic [DW-1:0] MAX_DIGITS = DW'(N_DIGITS);
    localparam logic [3:0] CODE_STAR = 4'd14;
    localparam logic [3:0] CODE_HASH = 4'd15;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_ack;
    logic [3:0]      r_code;
    logic            r_strobe;
    logic            r_sel;
    logic [DW-1:0]   r_cnt;
    logic [OW-1:0]   r_a;
    logic [OW-1:0]   r_b;
    logic            r_valid;

    logic            w_accept;
    logic            w_well_formed;
    logic            w_take;
    logic            w_is_digit;
    logic [1:0]      w_row_idx;
    logic [1:0]      w_col_idx;
    logic [3:0]      w_code;

    // Fixed 4x4 map: row-major, "123A / 456B / 789C / *0#D".
    function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_lut = 4'd1;   4'h1: key_lut = 4'd2;   4'h2: key_lut = 4'd3;   4'h3: key_lut = 4'd10;
            4'h4: key_lut = 4'd4;   4'h5: key_lut = 4'd5;   4'h6: key_lut = 4'd6;   4'h7: key_lut = 4'd11;
            4'h8: key_lut = 4'd7;   4'h9: key_lut = 4'd8;   4'hA: key_lut = 4'd9;   4'hB: key_lut = 4'd12;
            4'hC: key_lut = 4'd14;  4'hD: key_lut = 4'd0;   4'hE: key_lut = 4'd15;  default: key_lut = 4'd13;
        endcase
    endfunction

    always_comb begin
        w_row_idx = '0;
        w_col_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pressed_row_in[i]) w_row_idx = 2'(i);
            if (pressed_col_in[i]) w_col_idx = 2'(i);
        end
    end

    assign w_accept      = pressed_valid && !r_ack;
    assign w_well_formed = $onehot(pressed_row_in) && $onehot(pressed_col_in);
    assign w_take        = w_accept && w_well_formed;
    assign w_code        = key_lut(w_row_idx, w_col_idx);
    assign w_is_digit    = (w_code <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ENTER_A;
            r_ack    <= 1'b0;
            r_code   <= '0;
            r_strobe <= 1'b0;
            r_sel    <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_ack    <= w_accept;
            r_strobe <= w_take;
            if (w_take) r_code <= w_code;

            case (r_state)
                ENTER_A, ENTER_B: begin
                    if (w_take) begin
                        if (w_is_digit) begin
                            if (r_cnt < MAX_DIGITS) begin
                                if (r_state == ENTER_A) r_a <= {r_a[OW-5:0], w_code};
                                else                    r_b <= {r_b[OW-5:0], w_code};
                                r_cnt <= r_cnt + DW'(1);
                            end
                        end else if (w_code == CODE_STAR) begin
                            if (r_state == ENTER_A) r_a <= '0;
                            else                    r_b <= '0;
                            r_cnt <= '0;
                        end else if (w_code == CODE_HASH) begin
                            r_cnt <= '0;
                            if (r_state == ENTER_A) begin
                                r_state <= ENTER_B;
                                r_sel   <= 1'b1;
                            end else begin
                                r_state <= OUT;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                end
                OUT: begin
                    // Keys here are acked/strobed above but never touch the operands.
                    if (result_ready) begin
                        r_state <= ENTER_A;
                        r_valid <= 1'b0;
                        r_sel   <= 1'b0;
                        r_cnt   <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                    end
                end
                default: r_state <= ENTER_A;
            endcase
        end
    end

    assign ack_read     = r_ack;
    assign key_code     = r_code;
    assign key_strobe   = r_strobe;
    assign entry_sel    = r_sel;
    assign digit_count  = r_cnt;
    assign operand_a    = r_a;
    assign operand_b    = r_b;
    assign result_valid = r_valid;

endmodule
